fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch stage bus: pipeline control, instruction memory port and IF/ID outputs.
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] pc_plus1;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_count;

  // Upstream/control side: drives control and returns memory data
  modport master (
    output stall, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, instruction, pc_plus1, valid, halted, fetch_count
  );

  // Fetch stage side
  modport slave (
    input  stall, flush, branch_taken, branch_target, imem_data,
    output imem_addr, instruction, pc_plus1, valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, IF/ID register and RUN/HALTED FSM.
// Edge priority: rst > branch_taken > HALTED > flush > stall > normal fetch.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.slave  if_fetch
);

  localparam int unsigned W = 16;
  localparam logic [W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_pc, w_pc_nxt;
  logic [W-1:0] r_instr, w_instr_nxt;
  logic [W-1:0] r_pcp1, w_pcp1_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_halted;

  logic [W-1:0] w_pc_inc;
  logic         w_normal;
  logic         w_is_halt;

  assign w_pc_inc  = r_pc + W'(1);
  assign w_normal  = (r_state == ST_RUN) && !if_fetch.branch_taken &&
                     !if_fetch.flush && !if_fetch.stall;
  assign w_is_halt = (if_fetch.imem_data == HALT_INSTR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state: a branch always resumes; a normally captured halt word stops fetch
  always_comb begin
    w_state_nxt = r_state;
    if (if_fetch.branch_taken)   w_state_nxt = ST_RUN;
    else if (w_normal && w_is_halt) w_state_nxt = ST_HALTED;
  end

  // Next PC, IF/ID contents and fetch counter
  always_comb begin
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pcp1_nxt  = r_pcp1;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    if (if_fetch.branch_taken) begin
      w_pc_nxt    = if_fetch.branch_target;
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
    end else if (r_state == ST_HALTED) begin
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
    end else if (if_fetch.flush) begin
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      if (!if_fetch.stall) w_pc_nxt = w_pc_inc;
    end else if (!if_fetch.stall) begin
      w_instr_nxt = if_fetch.imem_data;
      w_pcp1_nxt  = w_pc_inc;
      w_valid_nxt = 1'b1;
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + W'(1);
      // The halt word issues but leaves the PC on itself
      if (!w_is_halt) w_pc_nxt = w_pc_inc;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_pcp1   <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pcp1   <= w_pcp1_nxt;
      r_valid  <= w_valid_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
    end
  end

  assign if_fetch.imem_addr   = r_pc;
  assign if_fetch.instruction = r_instr;
  assign if_fetch.pc_plus1    = r_pcp1;
  assign if_fetch.valid       = r_valid;
  assign if_fetch.halted      = r_halted;
  assign if_fetch.fetch_count = r_cnt;

endmodule
